// File: rtl/pll_reconfig_seq.sv
// Avalon-MM writer that loads a new M/N/K/C0 counter set into the Cyclone V
// PLL reconfiguration core, triggers the retune and waits for the PLL to relock.
module pll_reconfig_seq #(
    parameter int LOCK_TIMEOUT = 1048576,
    parameter bit N_BYPASS     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  m_hi,
    input  logic [7:0]  m_lo,
    input  logic        m_odd,
    input  logic [31:0] frac_k,
    input  logic [7:0]  c0_hi,
    input  logic [7:0]  c0_lo,
    input  logic        c0_odd,
    input  logic        pll_locked,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic [31:0] mgmt_writedata,
    input  logic        mgmt_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int CNT_W = (LOCK_TIMEOUT > 2) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [31:0] N_WORD = N_BYPASS ? 32'h0001_0000 : 32'h0000_0101;

    typedef enum logic [3:0] {
        S_IDLE,
        S_MODE,
        S_WR_N,
        S_WR_M,
        S_WR_K,
        S_WR_C,
        S_START,
        S_WAIT_LOCK,
        S_DONE,
        S_ERR
    } state_t;

    state_t state, state_next;

    logic [7:0]       m_hi_h, m_lo_h, c0_hi_h, c0_lo_h;
    logic             m_odd_h, c0_odd_h;
    logic [31:0]      frac_k_h;
    logic [CNT_W-1:0] lock_cnt;
    logic             lock_p0, lock_s, lock_prev;
    logic             wr_next, busy_next;
    logic [5:0]       addr_next;
    logic [31:0]      data_next;

    always_comb begin
        state_next = state;
        wr_next    = 1'b0;
        addr_next  = '0;
        data_next  = '0;
        case (state)
            S_IDLE:      if (start) state_next = S_MODE;
            S_MODE:      if (!mgmt_waitrequest) state_next = S_WR_N;
            S_WR_N:      if (!mgmt_waitrequest) state_next = S_WR_M;
            S_WR_M:      if (!mgmt_waitrequest) state_next = S_WR_K;
            S_WR_K:      if (!mgmt_waitrequest) state_next = S_WR_C;
            S_WR_C:      if (!mgmt_waitrequest) state_next = S_START;
            S_START:     if (!mgmt_waitrequest) state_next = S_WAIT_LOCK;
            // A qualified lock on the final count still counts as success.
            S_WAIT_LOCK: begin
                if (lock_s && lock_prev)     state_next = S_DONE;
                else if (lock_cnt == CNT_LAST) state_next = S_ERR;
            end
            S_DONE, S_ERR: state_next = S_IDLE;
            default:       state_next = S_IDLE;
        endcase

        // Bus fields follow the next state so they hold steady through a stall.
        case (state_next)
            S_MODE:  begin wr_next = 1'b1; addr_next = 6'h00; data_next = 32'h0000_0000; end
            S_WR_N:  begin wr_next = 1'b1; addr_next = 6'h03; data_next = N_WORD; end
            S_WR_M:  begin wr_next = 1'b1; addr_next = 6'h04;
                           data_next = {14'b0, m_odd_h, 1'b0, m_hi_h, m_lo_h}; end
            S_WR_K:  begin wr_next = 1'b1; addr_next = 6'h07; data_next = frac_k_h; end
            S_WR_C:  begin wr_next = 1'b1; addr_next = 6'h05;
                           data_next = {9'b0, 5'd0, c0_odd_h, 1'b0, c0_hi_h, c0_lo_h}; end
            S_START: begin wr_next = 1'b1; addr_next = 6'h02; data_next = 32'h0000_0001; end
            default: ;
        endcase

        busy_next = state_next inside {S_MODE, S_WR_N, S_WR_M, S_WR_K, S_WR_C,
                                       S_START, S_WAIT_LOCK};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            mgmt_write     <= 1'b0;
            mgmt_address   <= '0;
            mgmt_writedata <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            lock_cnt       <= '0;
            lock_p0        <= 1'b0;
            lock_s         <= 1'b0;
            lock_prev      <= 1'b0;
        end else begin
            state          <= state_next;
            mgmt_write     <= wr_next;
            mgmt_address   <= addr_next;
            mgmt_writedata <= data_next;
            busy           <= busy_next;
            done           <= (state_next == S_DONE);
            error          <= (state_next == S_ERR);
            lock_cnt       <= (state == S_WAIT_LOCK) ? lock_cnt + 1'b1 : '0;
            lock_p0        <= pll_locked;
            lock_s         <= lock_p0;
            // Lock history only counts samples taken while waiting for relock.
            lock_prev      <= (state == S_WAIT_LOCK) ? lock_s : 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE && start) begin
            m_hi_h   <= m_hi;
            m_lo_h   <= m_lo;
            m_odd_h  <= m_odd;
            frac_k_h <= frac_k;
            c0_hi_h  <= c0_hi;
            c0_lo_h  <= c0_lo;
            c0_odd_h <= c0_odd;
        end
    end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Randomized bench for pll_reconfig_seq: write order/data, stall behaviour,
// lock qualification and timeout checked against a cycle-level reference.
module tb_pll_reconfig_seq;

    localparam int T    = 16;
    localparam int HIST = 16384;

    logic        clk = 1'b0;
    logic        rst, start, m_odd, c0_odd, pll_locked, mgmt_write, mgmt_waitrequest;
    logic [7:0]  m_hi, m_lo, c0_hi, c0_lo;
    logic [31:0] frac_k, mgmt_writedata;
    logic [5:0]  mgmt_address;
    logic        busy, done, error;

    pll_reconfig_seq #(.LOCK_TIMEOUT(T), .N_BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .m_hi(m_hi), .m_lo(m_lo), .m_odd(m_odd),
        .frac_k(frac_k), .c0_hi(c0_hi), .c0_lo(c0_lo), .c0_odd(c0_odd),
        .pll_locked(pll_locked), .mgmt_address(mgmt_address), .mgmt_write(mgmt_write),
        .mgmt_writedata(mgmt_writedata), .mgmt_waitrequest(mgmt_waitrequest),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct { logic [5:0] addr; logic [31:0] data; int cyc; } wr_t;

    int          total = 0, bad = 0;
    int          cyc = 0, stab_bad = 0, both_bad = 0;
    wr_t         wr_q[$];
    int          done_q[$], err_q[$];
    logic        pl_hist[HIST];
    logic        busy_hist[HIST];
    logic        prev_stall = 1'b0;
    logic [5:0]  prev_addr = '0;
    logic [31:0] prev_data = '0;

    logic [7:0]  cfg_m_hi, cfg_m_lo, cfg_c0_hi, cfg_c0_lo;
    logic        cfg_m_odd, cfg_c0_odd;
    logic [31:0] cfg_k;
    int          stall_tab[6];
    int          lock_mode, glitch_n;
    int          exp_addr[6] = '{0, 3, 4, 7, 5, 2};

    always @(negedge clk) begin
        if (cyc < HIST) begin
            pl_hist[cyc]   = pll_locked;
            busy_hist[cyc] = busy;
        end
        if (mgmt_write && !mgmt_waitrequest) wr_q.push_back('{mgmt_address, mgmt_writedata, cyc});
        if (done) done_q.push_back(cyc);
        if (error) err_q.push_back(cyc);
        if (done && error) both_bad++;
        if (!rst && prev_stall && (!mgmt_write || mgmt_address != prev_addr || mgmt_writedata != prev_data))
            stab_bad++;
        prev_stall = !rst && mgmt_write && mgmt_waitrequest;
        prev_addr  = mgmt_address;
        prev_data  = mgmt_writedata;
        cyc++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] exp_word(input int idx);
        case (idx)
            0: return 32'h0;
            1: return 32'h0001_0000;
            2: return {14'b0, cfg_m_odd, 1'b0, cfg_m_hi, cfg_m_lo};
            3: return cfg_k;
            4: return {9'b0, 5'd0, cfg_c0_odd, 1'b0, cfg_c0_hi, cfg_c0_lo};
            default: return 32'h1;
        endcase
    endfunction

    // Relock outcome from the pll_locked history: two-flop delay, then two
    // consecutive high samples inside the wait window, else timeout.
    function automatic void model_lock(input int c, output bit is_done, output int when);
        bit prev = 1'b0;
        bit s;
        is_done = 1'b0;
        when    = -1;
        for (int i = 0; i < T; i++) begin
            s = pl_hist[c + 1 + i - 2];
            if (i >= 1 && s && prev) begin
                is_done = 1'b1; when = c + 2 + i; return;
            end
            if (i == T - 1) begin
                when = c + 2 + i; return;
            end
            prev = s;
        end
    endfunction

    function automatic void rand_cfg();
        cfg_m_hi   = 8'($urandom);
        cfg_m_lo   = 8'($urandom);
        cfg_m_odd  = 1'($urandom);
        cfg_k      = $urandom;
        cfg_c0_hi  = 8'($urandom);
        cfg_c0_lo  = 8'($urandom);
        cfg_c0_odd = 1'($urandom);
    endfunction

    task automatic run_txn(input bit restart_k, input logic [7:0] alt_mhi,
                           input bit start_on_done, output bit timed_out);
        int  stall_left[6];
        bit  did_restart;
        int  w;
        for (int k = 0; k < 6; k++) stall_left[k] = stall_tab[k];
        m_hi = cfg_m_hi; m_lo = cfg_m_lo; m_odd = cfg_m_odd; frac_k = cfg_k;
        c0_hi = cfg_c0_hi; c0_lo = cfg_c0_lo; c0_odd = cfg_c0_odd;
        pll_locked = (lock_mode == 0);
        mgmt_waitrequest = 1'b0;
        wr_q.delete(); done_q.delete(); err_q.delete();
        timed_out = 1'b1;
        did_restart = 1'b0;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int n = 0; n < 400; n++) begin
            w = wr_q.size();
            if (done || error) begin
                timed_out = 1'b0;
                start = start_on_done;
                mgmt_waitrequest = 1'b0;
                break;
            end
            mgmt_waitrequest = 1'b0;
            if (mgmt_write && w < 6 && stall_left[w] > 0) begin
                mgmt_waitrequest = 1'b1;
                stall_left[w]--;
            end
            case (lock_mode)
                0: pll_locked = 1'b1;
                1: pll_locked = 1'b0;
                2: pll_locked = (n == glitch_n);
                default: pll_locked = 1'($urandom);
            endcase
            if (restart_k && !did_restart && mgmt_write && mgmt_address == 6'h07) begin
                start = 1'b1; m_hi = alt_mhi; did_restart = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; mgmt_waitrequest = 1'b0; pll_locked = 1'b1;
        m_hi = '0; m_lo = '0; m_odd = 1'b0; frac_k = '0; c0_hi = '0; c0_lo = '0; c0_odd = 1'b0;
        repeat (3) @(posedge clk);
        #1; start = 1'b0;
        total++; if (mgmt_write !== 1'b0) begin bad++; $display("FAIL reset_write got=%b want=0", mgmt_write); end
        total++; if (mgmt_address !== 6'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", mgmt_address); end
        total++; if (mgmt_writedata !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", mgmt_writedata); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (error !== 1'b0) begin bad++; $display("FAIL reset_error got=%b want=0", error); end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_basic();
        bit to;
        logic [5:0]  a_ref[6] = '{6'h00, 6'h03, 6'h04, 6'h07, 6'h05, 6'h02};
        logic [31:0] d_ref[6] = '{32'h0, 32'h0001_0000, 32'h0002_0706, 32'h5C28_F5C3, 32'h0000_0202, 32'h1};
        cfg_m_hi = 8'd7; cfg_m_lo = 8'd6; cfg_m_odd = 1'b1; cfg_k = 32'h5C28_F5C3;
        cfg_c0_hi = 8'd2; cfg_c0_lo = 8'd2; cfg_c0_odd = 1'b0;
        stall_tab = '{0, 0, 0, 0, 0, 0}; lock_mode = 0;
        run_txn(1'b0, 8'h0, 1'b0, to);
        total++; if (to) begin bad++; $display("FAIL basic_timeout got=no_exit want=exit"); end
        total++; if (wr_q.size() !== 6) begin bad++; $display("FAIL basic_count got=%0d want=6", wr_q.size()); end
        for (int i = 0; i < 6 && i < wr_q.size(); i++) begin
            total++;
            if (wr_q[i].addr !== a_ref[i] || wr_q[i].data !== d_ref[i] || wr_q[i].cyc !== wr_q[0].cyc + i) begin
                bad++;
                $display("FAIL basic_write%0d got=%h/%h@%0d want=%h/%h@%0d", i, wr_q[i].addr, wr_q[i].data,
                         wr_q[i].cyc, a_ref[i], d_ref[i], wr_q[0].cyc + i);
            end
        end
        total++; if (done_q.size() !== 1 || err_q.size() !== 0) begin bad++;
            $display("FAIL basic_done got=%0d/%0d want=1/0", done_q.size(), err_q.size()); end
        if (wr_q.size() == 6 && done_q.size() == 1) begin
            for (int c = wr_q[0].cyc; c < done_q[0]; c++) begin
                total++; if (busy_hist[c] !== 1'b1) begin bad++; $display("FAIL basic_busy@%0d got=%b want=1", c, busy_hist[c]); end
            end
            total++; if (busy_hist[done_q[0]] !== 1'b0) begin bad++; $display("FAIL basic_busy_done got=%b want=0", busy_hist[done_q[0]]); end
            total++; if (done_q[0] !== wr_q[5].cyc + 3) begin bad++; $display("FAIL basic_done_cyc got=%0d want=%0d", done_q[0], wr_q[5].cyc + 3); end
        end
    endtask

    task automatic test_stall();
        bit to;
        int s0;
        s0 = stab_bad;
        cfg_m_hi = 8'd7; cfg_m_lo = 8'd6; cfg_m_odd = 1'b1; cfg_k = 32'h5C28_F5C3;
        cfg_c0_hi = 8'd2; cfg_c0_lo = 8'd2; cfg_c0_odd = 1'b0;
        stall_tab = '{0, 0, 5, 0, 0, 20}; lock_mode = 0;
        run_txn(1'b0, 8'h0, 1'b0, to);
        total++; if (to || wr_q.size() !== 6) begin bad++; $display("FAIL stall_count got=%0d want=6", wr_q.size()); end
        for (int i = 0; i < 6 && i < wr_q.size(); i++) begin
            total++;
            if (wr_q[i].addr !== 6'(exp_addr[i]) || wr_q[i].data !== exp_word(i)) begin
                bad++; $display("FAIL stall_write%0d got=%h/%h want=%h/%h", i, wr_q[i].addr, wr_q[i].data, exp_addr[i], exp_word(i));
            end
        end
        if (wr_q.size() == 6) begin
            total++; if (wr_q[2].cyc - wr_q[1].cyc !== 6) begin bad++; $display("FAIL stall_m_gap got=%0d want=6", wr_q[2].cyc - wr_q[1].cyc); end
            total++; if (wr_q[5].cyc - wr_q[4].cyc !== 21) begin bad++; $display("FAIL stall_start_gap got=%0d want=21", wr_q[5].cyc - wr_q[4].cyc); end
        end
        total++; if (stab_bad !== s0) begin bad++; $display("FAIL stall_stable got=%0d want=%0d", stab_bad, s0); end
        total++; if (done_q.size() !== 1) begin bad++; $display("FAIL stall_done got=%0d want=1", done_q.size()); end
    endtask

    task automatic test_timeout();
        bit to;
        rand_cfg();
        stall_tab = '{0, 1, 0, 2, 0, 0}; lock_mode = 1;
        run_txn(1'b0, 8'h0, 1'b0, to);
        total++; if (to || err_q.size() !== 1 || done_q.size() !== 0) begin bad++;
            $display("FAIL timeout_pulses got=err%0d/done%0d want=err1/done0", err_q.size(), done_q.size()); end
        if (err_q.size() == 1 && wr_q.size() == 6) begin
            total++; if (err_q[0] !== wr_q[5].cyc + 1 + T) begin bad++;
                $display("FAIL timeout_cyc got=%0d want=%0d", err_q[0], wr_q[5].cyc + 1 + T); end
            total++; if (busy_hist[err_q[0]] !== 1'b0 || busy_hist[err_q[0] - 1] !== 1'b1) begin bad++;
                $display("FAIL timeout_busy got=%b%b want=10", busy_hist[err_q[0] - 1], busy_hist[err_q[0]]); end
        end
    endtask

    task automatic test_restart_ignored();
        bit to;
        rand_cfg();
        stall_tab = '{0, 0, 0, 0, 0, 0}; lock_mode = 0;
        run_txn(1'b1, ~cfg_m_hi, 1'b0, to);
        total++; if (to || wr_q.size() !== 6) begin bad++; $display("FAIL restart_count got=%0d want=6", wr_q.size()); end
        for (int i = 0; i < 6 && i < wr_q.size(); i++) begin
            total++;
            if (wr_q[i].addr !== 6'(exp_addr[i]) || wr_q[i].data !== exp_word(i)) begin
                bad++; $display("FAIL restart_write%0d got=%h/%h want=%h/%h", i, wr_q[i].addr, wr_q[i].data, exp_addr[i], exp_word(i));
            end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL restart_idle got=%b want=0", busy); end
    endtask

    task automatic test_reset_mid();
        bit to;
        int st;
        rand_cfg();
        m_hi = cfg_m_hi; m_lo = cfg_m_lo; m_odd = cfg_m_odd; frac_k = cfg_k;
        c0_hi = cfg_c0_hi; c0_lo = cfg_c0_lo; c0_odd = cfg_c0_odd;
        pll_locked = 1'b0; mgmt_waitrequest = 1'b0;
        wr_q.delete();
        st = 0;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int n = 0; n < 60; n++) begin
            mgmt_waitrequest = mgmt_write && (mgmt_address == 6'h05);
            if (mgmt_waitrequest) st++;
            if (st == 4) break;
            @(posedge clk); #1;
        end
        total++; if (st !== 4) begin bad++; $display("FAIL rstmid_reach_wrc got=%0d want=4", st); end
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if (mgmt_write !== 1'b0 || busy !== 1'b0) begin bad++;
            $display("FAIL rstmid_drop got=%b/%b want=0/0", mgmt_write, busy); end
        rst = 1'b0; mgmt_waitrequest = 1'b0;
        total++; if (wr_q.size() !== 4) begin bad++; $display("FAIL rstmid_partial got=%0d want=4", wr_q.size()); end
        rand_cfg();
        stall_tab = '{0, 0, 0, 0, 0, 0}; lock_mode = 0;
        run_txn(1'b0, 8'h0, 1'b0, to);
        total++; if (to || wr_q.size() !== 6) begin bad++; $display("FAIL rstmid_replay_count got=%0d want=6", wr_q.size()); end
        for (int i = 0; i < 6 && i < wr_q.size(); i++) begin
            total++;
            if (wr_q[i].addr !== 6'(exp_addr[i]) || wr_q[i].data !== exp_word(i)) begin
                bad++; $display("FAIL rstmid_write%0d got=%h/%h want=%h/%h", i, wr_q[i].addr, wr_q[i].data, exp_addr[i], exp_word(i));
            end
        end
    endtask

    task automatic test_glitch();
        bit to, ed;
        int ew;
        rand_cfg();
        stall_tab = '{0, 0, 0, 0, 0, 0}; lock_mode = 2; glitch_n = 10;
        run_txn(1'b0, 8'h0, 1'b0, to);
        total++; if (to || done_q.size() !== 0 || err_q.size() !== 1) begin bad++;
            $display("FAIL glitch_outcome got=done%0d/err%0d want=done0/err1", done_q.size(), err_q.size()); end
        if (wr_q.size() == 6 && err_q.size() == 1) begin
            model_lock(wr_q[5].cyc, ed, ew);
            total++; if (ed !== 1'b0 || err_q[0] !== ew) begin bad++;
                $display("FAIL glitch_cyc got=%0d want=%0d", err_q[0], ew); end
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        rand_cfg();
        stall_tab = '{0, 0, 0, 0, 0, 0}; lock_mode = 0;
        run_txn(1'b0, 8'h0, 1'b1, to);
        total++; if (to || done_q.size() !== 1 || wr_q.size() !== 6) begin bad++;
            $display("FAIL b2b_start_on_done got=done%0d/wr%0d want=done1/wr6", done_q.size(), wr_q.size()); end
        total++; if (busy !== 1'b0 || mgmt_write !== 1'b0) begin bad++;
            $display("FAIL b2b_ignored got=%b/%b want=0/0", busy, mgmt_write); end
        rand_cfg();
        run_txn(1'b0, 8'h0, 1'b0, to);
        total++; if (to || done_q.size() !== 1 || wr_q.size() !== 6) begin bad++;
            $display("FAIL b2b_second got=done%0d/wr%0d want=done1/wr6", done_q.size(), wr_q.size()); end
        if (wr_q.size() == 6) begin
            total++; if (wr_q[2].data !== exp_word(2) || wr_q[4].data !== exp_word(4)) begin bad++;
                $display("FAIL b2b_data got=%h/%h want=%h/%h", wr_q[2].data, wr_q[4].data, exp_word(2), exp_word(4)); end
        end
    endtask

    task automatic test_random();
        bit to, ed;
        int ew;
        for (int it = 0; it < 10; it++) begin
            rand_cfg();
            for (int k = 0; k < 6; k++) stall_tab[k] = int'($urandom_range(3));
            lock_mode = int'($urandom_range(3));
            glitch_n  = int'($urandom_range(30, 8));
            run_txn(1'b0, 8'h0, 1'b0, to);
            total++; if (to || wr_q.size() !== 6) begin bad++; $display("FAIL rand%0d_count got=%0d want=6", it, wr_q.size()); end
            for (int i = 0; i < 6 && i < wr_q.size(); i++) begin
                total++;
                if (wr_q[i].addr !== 6'(exp_addr[i]) || wr_q[i].data !== exp_word(i)) begin
                    bad++; $display("FAIL rand%0d_write%0d got=%h/%h want=%h/%h", it, i, wr_q[i].addr, wr_q[i].data, exp_addr[i], exp_word(i));
                end
            end
            if (wr_q.size() == 6) begin
                model_lock(wr_q[5].cyc, ed, ew);
                total++;
                if ((ed && (done_q.size() !== 1 || err_q.size() !== 0 || done_q[0] !== ew)) ||
                    (!ed && (err_q.size() !== 1 || done_q.size() !== 0 || err_q[0] !== ew))) begin
                    bad++; $display("FAIL rand%0d_outcome got=done%0d/err%0d want=%s@%0d", it, done_q.size(), err_q.size(),
                                    ed ? "done" : "err", ew);
                end
            end
        end
    endtask

    task automatic test_invariants();
        total++; if (both_bad !== 0) begin bad++; $display("FAIL done_and_error got=%0d want=0", both_bad); end
        total++; if (stab_bad !== 0) begin bad++; $display("FAIL stall_stability got=%0d want=0", stab_bad); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_timeout();
        test_restart_ignored();
        test_reset_mid();
        test_glitch();
        test_back_to_back();
        test_random();
        test_invariants();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
